nfc_rng_chk: RTL and testbench
==============================

Name: nfc_rng_chk

Overview:
Downstream consumer of the NFC random-data generator. During NAND read-back test it drives the generator's en/rd, compares each received flash byte against the expected rng_dat, counts mismatches and logs the first failing byte. Sits between the NFC read datapath (byte stream from flash buffer) and the test/status register block.

Parameters:
LEN_W, 16, width of byte-length counter, error counter and error-address register

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin a check run (ignored while busy)
abort  input  1  one-cycle pulse; terminate run immediately
byte_len  input  LEN_W  number of bytes to check; sampled on start
dat_vld  input  1  dat_in carries a valid read byte this cycle
dat_in  input  8  flash read byte
rng_dat  input  8  expected byte from generator (combinational on generator side)
rng_en  output  1  generator enable; rising edge loads seed
rng_rd  output  1  generator advance strobe
busy  output  1  run in progress
done  output  1  one-cycle pulse at run end (normal or abort)
err_flag  output  1  at least one mismatch in last run
err_cnt  output  LEN_W  mismatch count, saturating at all-ones
err_addr  output  LEN_W  byte index (0-based) of first mismatch
err_exp  output  8  expected byte at first mismatch
err_got  output  8  received byte at first mismatch

Behaviour:
- Reset: all outputs 0, FSM IDLE, internal byte counter 0.
- FSM states IDLE, SEED, RUN, FIN.
- IDLE: start=1 and byte_len!=0 -> SEED; clear err_cnt, err_flag, err_addr, err_exp, err_got, byte counter; latch byte_len. start=1 with byte_len==0 -> FIN directly, rng_en never asserted, error regs cleared.
- SEED (exactly 1 cycle): rng_en=1, rng_rd=0, dat_vld ignored; generator loads seed on this edge. -> RUN.
- RUN: rng_en=1; rng_rd = dat_vld (combinational, same cycle). When dat_vld=1: compare dat_in with rng_dat; byte counter +1. Mismatch: err_cnt+1 (hold at max), err_flag<=1; if err_flag was 0, capture err_addr=current byte index, err_exp=rng_dat, err_got=dat_in. Results visible the cycle after the byte.
- RUN -> FIN on the edge accepting byte index byte_len-1; bytes arriving afterward are ignored and do not pulse rng_rd.
- FIN (1 cycle): rng_en=0, rng_rd=0, done=1 -> IDLE.
- busy=1 in SEED, RUN, FIN.
- abort in SEED or RUN: -> FIN next edge, rng_en drops that edge; a byte accepted in the same cycle as abort is still compared/counted. abort in IDLE/FIN ignored. abort has priority over start.
- start while busy: ignored.
- Error regs hold after done until next accepted start.
- Async reset mid-run: immediate return to IDLE, all outputs 0, no done pulse.
- Checker is mode-agnostic; LFSR, increment and decrement generator modes all checked identically.

Optional Feature:
NFC_RNG_CHK_DESCR_EN: when defined, adds outputs dat_out[7:0] and dat_out_vld; in RUN, for each accepted byte dat_out = dat_in XOR rng_dat, registered, dat_out_vld pulses one cycle after the byte (descrambled read data for the host buffer). Reset value 0. When undefined these ports and registers do not exist; checking behaviour identical in both builds.

Test Plan:
- Generator mode 00, seed 0x12345678, byte_len=5, dat_in 12,F0,AC,68,24 with dat_vld every cycle -> rng_rd 5 pulses, done 1 cycle after 5th byte, err_flag=0, err_cnt=0.
- Same as above but 3rd byte 0xAD -> err_cnt=1, err_addr=2, err_exp=0xAC, err_got=0xAD; later 5th byte 0x00 -> err_cnt=2, first-error regs unchanged.
- Mode 10, seed 0xA5000000, byte_len=4, dat_vld gapped (1,0,0,1,1,0,1), bytes A5,A6,A7,A8 -> no errors, rng_rd only on dat_vld cycles, done after 4th byte.
- byte_len=0 start -> done 1 cycle later, rng_en stays 0, busy high 1 cycle.
- abort after 2 of 8 bytes -> rng_en low next cycle, done pulse, err_cnt reflects 2 bytes; start during run ignored; rst_n low mid-run -> all outputs 0, no done.
- With NFC_RNG_CHK_DESCR_EN, seed 0x12345678, dat_in 0x00 x5 -> dat_out 12,F0,AC,68,24, each one cycle after input.

Source files
------------

// File: rtl/nfc_rng_chk_if.sv
// ----------------------------------------------------------------------------
// nfc_rng_chk_if
// Bundles the read-data stream coming from the NFC flash buffer together with
// the link to the random-data generator, so the checker sees a single port.
//
// Signals:
//   dat_vld  - dat_in carries a valid flash read byte this cycle
//   dat_in   - flash read byte
//   rng_dat  - expected byte from the generator (combinational on its side)
//   rng_en   - generator enable, its rising edge loads the seed
//   rng_rd   - generator advance strobe
//
// Modports:
//   master - read datapath / generator side (drives data, receives strobes)
//   slave  - checker side (receives data, drives strobes)
// ----------------------------------------------------------------------------
interface nfc_rng_chk_if;
   logic       dat_vld;
   logic [7:0] dat_in;
   logic [7:0] rng_dat;
   logic       rng_en;
   logic       rng_rd;

   modport master (
      output dat_vld,
      output dat_in,
      output rng_dat,
      input  rng_en,
      input  rng_rd
   );

   modport slave (
      input  dat_vld,
      input  dat_in,
      input  rng_dat,
      output rng_en,
      output rng_rd
   );
endinterface

// File: rtl/nfc_rng_chk.sv
// ----------------------------------------------------------------------------
// nfc_rng_chk
// Read-back checker for the NFC random-data generator. During a NAND read-back
// test it enables and advances the generator, compares each flash byte with
// the generator's expected byte, counts mismatches (saturating) and records
// index / expected / received value of the first failing byte.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - pulse, begin a run (ignored while busy)
//   abort               - pulse, end the current run at the next edge
//   byte_len            - number of bytes to check, sampled on start
//   rng_if (slave)      - dat_vld/dat_in from flash, rng_dat from generator,
//                         rng_en/rng_rd to generator
//   busy, done          - run in progress / one-cycle end-of-run pulse
//   err_flag, err_cnt   - any mismatch seen / mismatch count
//   err_addr, err_exp,
//   err_got             - first mismatch: byte index, expected, received
//
// Optional build macro NFC_RNG_CHK_DESCR_EN:
//   adds dat_out / dat_out_vld, the registered descrambled byte
//   (dat_in XOR rng_dat) for every accepted byte. Checking is identical
//   with or without it.
// ----------------------------------------------------------------------------
module nfc_rng_chk #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] byte_len,
   nfc_rng_chk_if.slave     rng_if,
   output logic             busy,
   output logic             done,
   output logic             err_flag,
   output logic [LEN_W-1:0] err_cnt,
   output logic [LEN_W-1:0] err_addr,
   output logic [7:0]       err_exp,
   output logic [7:0]       err_got
`ifdef NFC_RNG_CHK_DESCR_EN
   ,
   output logic [7:0]       dat_out,
   output logic             dat_out_vld
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEED,
      ST_RUN,
      ST_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_flag_q, err_flag_d;
   logic [LEN_W-1:0] err_addr_q, err_addr_d;
   logic [7:0]       err_exp_q, err_exp_d;
   logic [7:0]       err_got_q, err_got_d;

   logic accept;
   logic last_byte;
   logic mismatch;

   // A byte is only consumed while running; anything arriving in SEED or
   // after the final byte is dropped and never advances the generator.
   assign accept    = (state_q == ST_RUN) && rng_if.dat_vld;
   assign last_byte = (idx_q == LEN_W'(len_q - 1'b1));
   assign mismatch  = (rng_if.dat_in != rng_if.rng_dat);

   // State and all checker registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_got_q  <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         err_addr_q <= err_addr_d;
         err_exp_q  <= err_exp_d;
         err_got_q  <= err_got_d;
      end
   end

   // Next-state logic. Error registers are only cleared by an accepted start,
   // so the results of a finished run stay readable until the next one.
   // A zero-length run skips SEED so the generator is never enabled.
   // An abort coinciding with an accepted byte still lets that byte count.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      err_addr_d = err_addr_q;
      err_exp_d  = err_exp_q;
      err_got_d  = err_got_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               len_d      = byte_len;
               idx_d      = '0;
               err_cnt_d  = '0;
               err_flag_d = 1'b0;
               err_addr_d = '0;
               err_exp_d  = '0;
               err_got_d  = '0;
               state_d    = (byte_len == '0) ? ST_FIN : ST_SEED;
            end
         end

         ST_SEED: begin
            state_d = abort ? ST_FIN : ST_RUN;
         end

         ST_RUN: begin
            if (accept) begin
               idx_d = idx_q + 1'b1;
               if (mismatch) begin
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
                  err_flag_d = 1'b1;
                  if (!err_flag_q) begin
                     err_addr_d = idx_q;
                     err_exp_d  = rng_if.rng_dat;
                     err_got_d  = rng_if.dat_in;
                  end
               end
            end
            if (abort || (accept && last_byte)) begin
               state_d = ST_FIN;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status and generator strobes decode straight from the state register;
   // rng_rd follows dat_vld in the same cycle so the generator steps in
   // lock-step with the byte being compared.
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FIN);
   assign rng_if.rng_en = (state_q == ST_SEED) || (state_q == ST_RUN);
   assign rng_if.rng_rd = accept;

   assign err_flag = err_flag_q;
   assign err_cnt  = err_cnt_q;
   assign err_addr = err_addr_q;
   assign err_exp  = err_exp_q;
   assign err_got  = err_got_q;

`ifdef NFC_RNG_CHK_DESCR_EN
   logic [7:0] dat_out_q, dat_out_d;
   logic       dat_out_vld_q, dat_out_vld_d;

   // Descrambled read data: the generator stream XORed out of each
   // accepted byte, presented one cycle later with a single-cycle valid.
   always_comb begin
      dat_out_d     = dat_out_q;
      dat_out_vld_d = accept;
      if (accept) begin
         dat_out_d = rng_if.dat_in ^ rng_if.rng_dat;
      end
   end

   // Descrambler output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat_out_q     <= '0;
         dat_out_vld_q <= 1'b0;
      end else begin
         dat_out_q     <= dat_out_d;
         dat_out_vld_q <= dat_out_vld_d;
      end
   end

   assign dat_out     = dat_out_q;
   assign dat_out_vld = dat_out_vld_q;
`endif

endmodule

// File: tb/tb_nfc_rng_chk.sv
// ----------------------------------------------------------------------------
// tb_nfc_rng_chk
// Self-checking bench for nfc_rng_chk. A small generator model supplies
// rng_dat from a fixed byte sequence (loaded on rng_en rise, advanced on
// rng_rd). Table-driven runs plus hand-written abort / zero-length / reset
// sequences. Build with NFC_RNG_CHK_DESCR_EN to also check dat_out.
// ----------------------------------------------------------------------------
module tb_nfc_rng_chk;

   localparam int LEN_W = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] byte_len;
   logic             busy;
   logic             done;
   logic             err_flag;
   logic [LEN_W-1:0] err_cnt;
   logic [LEN_W-1:0] err_addr;
   logic [7:0]       err_exp;
   logic [7:0]       err_got;
`ifdef NFC_RNG_CHK_DESCR_EN
   logic [7:0]       dat_out;
   logic             dat_out_vld;
`endif

   nfc_rng_chk_if u_if ();

   nfc_rng_chk #(.LEN_W(LEN_W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .byte_len    (byte_len),
      .rng_if      (u_if.slave),
      .busy        (busy),
      .done        (done),
      .err_flag    (err_flag),
      .err_cnt     (err_cnt),
      .err_addr    (err_addr),
      .err_exp     (err_exp),
      .err_got     (err_got)
`ifdef NFC_RNG_CHK_DESCR_EN
      ,
      .dat_out     (dat_out),
      .dat_out_vld (dat_out_vld)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generator model: rising rng_en restarts the sequence, rng_rd steps it.
   logic [7:0] gen_seq [0:15];
   logic [3:0] gen_idx;
   logic       en_prev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_prev <= 1'b0;
         gen_idx <= '0;
      end else begin
         en_prev <= u_if.rng_en;
         if (u_if.rng_en && !en_prev) gen_idx <= '0;
         else if (u_if.rng_rd)        gen_idx <= gen_idx + 1'b1;
      end
   end

   assign u_if.rng_dat = gen_seq[gen_idx];

   int n_checks;
   int n_fails;
   int done_cnt;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   typedef struct {
      logic [LEN_W-1:0] cnt;
      logic             flag;
      logic [LEN_W-1:0] addr;
      logic [7:0]       exp_b;
      logic [7:0]       got_b;
      logic [7:0]       dout;
   } sb_t;

   sb_t sb_q [$];

   typedef struct {
      int               seq_sel;
      logic [LEN_W-1:0] len;
      int               ncyc;
      logic [15:0]      vld_mask;
      logic [63:0]      dat;
      logic [LEN_W-1:0] e_cnt;
      logic             e_flag;
      logic [LEN_W-1:0] e_addr;
      logic [7:0]       e_exp;
      logic [7:0]       e_got;
      int               e_rd;
   } vec_t;

   vec_t vecs [5];

   // Reference model of the error registers for the current run.
   logic [LEN_W-1:0] m_cnt;
   logic             m_flag;
   logic [LEN_W-1:0] m_addr;
   logic [7:0]       m_exp;
   logic [7:0]       m_got;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] bytes8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic load_seq(input int sel);
      for (int i = 0; i < 16; i++) gen_seq[i] = 8'h00;
      if (sel == 0) begin
         gen_seq[0] = 8'h12; gen_seq[1] = 8'hF0; gen_seq[2] = 8'hAC; gen_seq[3] = 8'h68;
         gen_seq[4] = 8'h24; gen_seq[5] = 8'h5A; gen_seq[6] = 8'hC3; gen_seq[7] = 8'h3C;
      end else begin
         for (int i = 0; i < 8; i++) gen_seq[i] = 8'hA5 + 8'(i);
      end
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      #1;
      if (i == 20) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL %s: busy still %0b after 20 cycles, expected 0", name, busy);
      end
   endtask

   task automatic start_run(input logic [LEN_W-1:0] len);
      @(negedge clk);
      start    = 1'b1;
      byte_len = len;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // One table-driven run: start, a garbage byte during SEED, then the byte
   // pattern; per-byte results go through the scoreboard.
   task automatic apply_stimulus(input vec_t v, input int vn);
      int   k;
      int   ptr;
      int   rd_seen;
      int   done_before;
      logic vld;
      logic acc;
      sb_t  e;
      sb_t  got;
      load_seq(v.seq_sel);
      m_cnt = '0; m_flag = 1'b0; m_addr = '0; m_exp = '0; m_got = '0;
      k = 0; ptr = 0; rd_seen = 0;
      done_before = done_cnt;
      start_run(v.len);
      check_output($sformatf("v%0d_seed_busy", vn), 32'(busy), 32'd1);
      check_output($sformatf("v%0d_seed_en", vn), 32'(u_if.rng_en), 32'd1);
      u_if.dat_vld = 1'b1;
      u_if.dat_in  = 8'hEE;
      #1;
      check_output($sformatf("v%0d_seed_rd", vn), 32'(u_if.rng_rd), 32'd0);
      @(negedge clk);
      for (int c = 0; c < v.ncyc; c++) begin
         vld = v.vld_mask[c];
         u_if.dat_vld = vld;
         u_if.dat_in  = vld ? v.dat[8*ptr +: 8] : 8'h00;
         acc = vld && (k < int'(v.len));
         #1;
         check_output($sformatf("v%0d_c%0d_rd", vn, c), 32'(u_if.rng_rd), 32'(acc));
         if (u_if.rng_rd === 1'b1) rd_seen++;
         if (acc) begin
            if (u_if.dat_in != gen_seq[k]) begin
               m_cnt++;
               if (!m_flag) begin
                  m_addr = LEN_W'(k);
                  m_exp  = gen_seq[k];
                  m_got  = u_if.dat_in;
               end
               m_flag = 1'b1;
            end
            e.cnt = m_cnt; e.flag = m_flag; e.addr = m_addr;
            e.exp_b = m_exp; e.got_b = m_got; e.dout = u_if.dat_in ^ gen_seq[k];
            sb_q.push_back(e);
            k++;
         end
         if (vld) ptr++;
         @(posedge clk);
         #1;
         if (acc) begin
            got = sb_q.pop_front();
            check_output($sformatf("v%0d_c%0d_cnt", vn, c), 32'(err_cnt), 32'(got.cnt));
            check_output($sformatf("v%0d_c%0d_flag", vn, c), 32'(err_flag), 32'(got.flag));
            check_output($sformatf("v%0d_c%0d_first", vn, c), {err_addr, err_exp, err_got},
                         {got.addr, got.exp_b, got.got_b});
`ifdef NFC_RNG_CHK_DESCR_EN
            check_output($sformatf("v%0d_c%0d_dout", vn, c), {23'd0, dat_out_vld, dat_out},
                         {23'd0, 1'b1, got.dout});
`endif
            if (k == int'(v.len))
               check_output($sformatf("v%0d_done_after_last", vn), 32'(done), 32'd1);
         end else begin
`ifdef NFC_RNG_CHK_DESCR_EN
            check_output($sformatf("v%0d_c%0d_dout_vld", vn, c), 32'(dat_out_vld), 32'd0);
`endif
         end
         @(negedge clk);
      end
      u_if.dat_vld = 1'b0;
      wait_idle($sformatf("v%0d_idle", vn));
      check_output($sformatf("v%0d_final_cnt", vn), 32'(err_cnt), 32'(v.e_cnt));
      check_output($sformatf("v%0d_final_flag", vn), 32'(err_flag), 32'(v.e_flag));
      check_output($sformatf("v%0d_final_first", vn), {err_addr, err_exp, err_got},
                   {v.e_addr, v.e_exp, v.e_got});
      check_output($sformatf("v%0d_rd_pulses", vn), 32'(rd_seen), 32'(v.e_rd));
      check_output($sformatf("v%0d_done_pulses", vn), 32'(done_cnt - done_before), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int done_ref;
      n_checks = 0; n_fails = 0; done_cnt = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_len = '0;
      u_if.dat_vld = 1'b0; u_if.dat_in = 8'h00;
      load_seq(0);

      vecs[0] = '{0, 16'd5, 5, 16'h1F, bytes8(8'h12, 8'hF0, 8'hAC, 8'h68, 8'h24, 0, 0, 0),
                  16'd0, 1'b0, 16'd0, 8'h00, 8'h00, 5};
      vecs[1] = '{0, 16'd5, 5, 16'h1F, bytes8(8'h12, 8'hF0, 8'hAD, 8'h68, 8'h00, 0, 0, 0),
                  16'd2, 1'b1, 16'd2, 8'hAC, 8'hAD, 5};
      vecs[2] = '{1, 16'd4, 7, 16'h59, bytes8(8'hA5, 8'hA6, 8'hA7, 8'hA8, 0, 0, 0, 0),
                  16'd0, 1'b0, 16'd0, 8'h00, 8'h00, 4};
      vecs[3] = '{0, 16'd3, 5, 16'h1F, bytes8(8'h12, 8'hF0, 8'hAC, 8'hFF, 8'hFF, 0, 0, 0),
                  16'd0, 1'b0, 16'd0, 8'h00, 8'h00, 3};
      vecs[4] = '{0, 16'd5, 5, 16'h1F, bytes8(0, 0, 0, 0, 0, 0, 0, 0),
                  16'd5, 1'b1, 16'd0, 8'h12, 8'h00, 5};

      // Reset state.
      repeat (3) @(negedge clk);
      check_output("rst_status", {busy, done, err_flag, u_if.rng_en, u_if.rng_rd}, 32'd0);
      check_output("rst_err", {err_cnt, err_addr}, 32'd0);
      check_output("rst_bytes", {err_exp, err_got}, 32'd0);
`ifdef NFC_RNG_CHK_DESCR_EN
      check_output("rst_dout", {dat_out_vld, dat_out}, 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

      // Zero-length run: straight to FIN, generator never enabled,
      // errors left by the previous run cleared.
      start_run(16'd0);
      check_output("zero_done", 32'(done), 32'd1);
      check_output("zero_busy", 32'(busy), 32'd1);
      check_output("zero_en", 32'(u_if.rng_en), 32'd0);
      check_output("zero_err_clr", {err_cnt, 15'd0, err_flag}, 32'd0);
      check_output("zero_first_clr", {err_addr, err_exp, err_got}, 32'd0);
      @(negedge clk);
      check_output("zero_after", {busy, done, u_if.rng_en}, 32'd0);

      // Abort after 2 of 8 bytes, second byte arriving with abort;
      // a start in between must be ignored.
      load_seq(0);
      done_ref = done_cnt;
      start_run(16'd8);
      @(negedge clk);
      u_if.dat_vld = 1'b1; u_if.dat_in = 8'h12;
      @(posedge clk); #1;
      @(negedge clk);
      u_if.dat_vld = 1'b0; start = 1'b1; byte_len = 16'd3;
      @(posedge clk); #1;
      check_output("abort_start_ignored", {busy, u_if.rng_en, done}, 32'b110);
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      u_if.dat_vld = 1'b1; u_if.dat_in = 8'h00;
      #1;
      check_output("abort_rd", 32'(u_if.rng_rd), 32'd1);
      @(posedge clk); #1;
      check_output("abort_en_drop", 32'(u_if.rng_en), 32'd0);
      check_output("abort_done", 32'(done), 32'd1);
      check_output("abort_cnt", {err_cnt, 15'd0, err_flag}, {16'd1, 15'd0, 1'b1});
      check_output("abort_first", {err_addr, err_exp, err_got}, {16'd1, 8'hF0, 8'h00});
      @(negedge clk);
      abort = 1'b0; u_if.dat_vld = 1'b0;
      wait_idle("abort_idle");
      check_output("abort_done_pulses", 32'(done_cnt - done_ref), 32'd1);

      // Asynchronous reset in the middle of a run.
      start_run(16'd5);
      @(negedge clk);
      u_if.dat_vld = 1'b1; u_if.dat_in = 8'hFF;
      @(posedge clk); #1;
      check_output("rstmid_cnt", 32'(err_cnt), 32'd1);
      @(negedge clk);
      u_if.dat_vld = 1'b0;
      done_ref = done_cnt;
      rst_n = 1'b0;
      #1;
      check_output("rstmid_status", {busy, done, err_flag, u_if.rng_en, u_if.rng_rd}, 32'd0);
      check_output("rstmid_err", {err_cnt, err_addr}, 32'd0);
      check_output("rstmid_bytes", {err_exp, err_got}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_output("rstmid_no_done", 32'(done_cnt - done_ref), 32'd0);
      check_output("rstmid_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
